// File: rtl/result_nibble_reader.sv
// Readout of the 8-bit adder result {carry, z} one nibble at a time on LEDs.
// Ports: clk, rstn, sum_in, carry_in, load_pb, next_pb -> led, nib_idx, done.

module result_nibble_reader_pb #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   deb;
  logic                   deb_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES consecutive
  // disagreeing synced samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
    end else begin
      deb_d <= deb;
      if (synced == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= synced;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign pulse = deb & ~deb_d;

endmodule

module result_nibble_reader #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] sum_in,
  input  logic       carry_in,
  input  logic       load_pb,
  input  logic       next_pb,
  output logic [3:0] led,
  output logic [1:0] nib_idx,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] res;
  logic [7:0] res_nx;
  logic       done_nx;
  logic [3:0] led_nx;
  logic       load_p;
  logic       next_p;

  result_nibble_reader_pb #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load (
    .clk  (clk),
    .rstn (rstn),
    .raw  (load_pb),
    .pulse(load_p)
  );

  result_nibble_reader_pb #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk  (clk),
    .rstn (rstn),
    .raw  (next_pb),
    .pulse(next_p)
  );

  // Load has priority over next in every state.
  always_comb begin
    state_nx = state;
    res_nx   = res;
    done_nx  = 1'b0;
    if (load_p) begin
      state_nx = HI;
      res_nx   = {carry_in, sum_in};
    end else if (next_p) begin
      unique case (state)
        HI: state_nx = LO;
        LO: begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
        default: state_nx = state;
      endcase
    end
  end

  // Outputs are registered from the next state so led tracks state.
  always_comb begin
    led_nx = 4'h0;
    unique case (state_nx)
      HI:      led_nx = res_nx[7:4];
      LO:      led_nx = res_nx[3:0];
      default: led_nx = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      res     <= 8'h00;
      led     <= 4'h0;
      nib_idx <= 2'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      res     <= res_nx;
      led     <= led_nx;
      nib_idx <= state_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_result_nibble_reader.sv
// Scoreboard bench for result_nibble_reader: button presses push the
// expected {led, nib_idx, done} and the DUT response is popped and compared.

module tb_result_nibble_reader;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [6:0] sum_in = 7'h00;
  logic       carry_in = 1'b0;
  logic       load_pb = 1'b0;
  logic       next_pb = 1'b0;
  logic [3:0] led;
  logic [1:0] nib_idx;
  logic       done;

  int vec = 0;
  int bad = 0;

  logic [6:0] sb[$];
  int         m_st = 0;
  logic [7:0] m_res = 8'h00;

  always #5 clk = ~clk;

  result_nibble_reader #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sum_in  (sum_in),
    .carry_in(carry_in),
    .load_pb (load_pb),
    .next_pb (next_pb),
    .led     (led),
    .nib_idx (nib_idx),
    .done    (done)
  );

  function automatic logic [6:0] model_out(input logic d);
    logic [3:0] l;
    l = (m_st == 1) ? m_res[7:4] : (m_st == 2) ? m_res[3:0] : 4'h0;
    return {l, 2'(m_st), d};
  endfunction

  function automatic logic [6:0] model_step(input bit ld, input bit nx);
    logic d;
    d = 1'b0;
    if (ld) begin
      m_res = {carry_in, sum_in};
      m_st  = 1;
    end else if (nx) begin
      if (m_st == 1) m_st = 2;
      else if (m_st == 2) begin
        m_st = 0;
        d = 1'b1;
      end
    end
    return model_out(d);
  endfunction

  task automatic do_press(input bit ld, input bit nx, input string nm,
                          input int extra);
    logic [6:0] cur;
    logic [6:0] exp;
    logic [6:0] obs;
    cur = model_out(1'b0);
    sb.push_back(model_step(ld, nx));
    @(negedge clk);
    load_pb = ld;
    next_pb = nx;
    for (int k = 1; k <= S + D; k++) begin
      @(posedge clk); #1;
      obs = {led, nib_idx, done};
      vec++;
      if (obs !== cur) begin
        bad++;
        $display("FAIL %s_early k=%0d got=%h want=%h", nm, k, obs, cur);
      end
    end
    @(posedge clk); #1;
    exp = sb.pop_front();
    obs = {led, nib_idx, done};
    vec++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s_resp got=%h want=%h", nm, obs, exp);
    end
    exp[0] = 1'b0;
    for (int k = 0; k < extra + 1; k++) begin
      @(posedge clk); #1;
      obs = {led, nib_idx, done};
      vec++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s_held k=%0d got=%h want=%h", nm, k, obs, exp);
      end
    end
    @(negedge clk);
    load_pb = 1'b0;
    next_pb = 1'b0;
    for (int k = 0; k < S + D + 3; k++) begin
      @(posedge clk); #1;
      obs = {led, nib_idx, done};
      vec++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s_rel k=%0d got=%h want=%h", nm, k, obs, exp);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    vec++;
    if ({led, nib_idx, done} !== 7'h00) begin
      bad++;
      $display("FAIL reset got=%h want=00", {led, nib_idx, done});
    end
    @(negedge clk);
    rstn = 1'b1;
    m_st = 0;
    m_res = 8'h00;
  endtask

  task automatic test_next_idle();
    do_press(1'b0, 1'b1, "next_idle", 0);
  endtask

  task automatic test_readout();
    sum_in = 7'b1001011;
    carry_in = 1'b1;
    do_press(1'b1, 1'b0, "ro_load", 0);
    vec++;
    if (led !== 4'b1100 || nib_idx !== 2'd1) begin
      bad++;
      $display("FAIL ro_hi led=%b idx=%0d want 1100/1", led, nib_idx);
    end
    do_press(1'b0, 1'b1, "ro_next1", 0);
    vec++;
    if (led !== 4'b1011 || nib_idx !== 2'd2) begin
      bad++;
      $display("FAIL ro_lo led=%b idx=%0d want 1011/2", led, nib_idx);
    end
    do_press(1'b0, 1'b1, "ro_next2", 0);
  endtask

  task automatic test_debounce();
    logic [6:0] cur;
    do_press(1'b1, 1'b0, "db_load", 0);
    cur = model_out(1'b0);
    @(negedge clk);
    next_pb = 1'b1;
    repeat (D - 1) @(posedge clk);
    @(negedge clk);
    next_pb = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      vec++;
      if ({led, nib_idx, done} !== cur) begin
        bad++;
        $display("FAIL glitch k=%0d got=%h want=%h", k,
                 {led, nib_idx, done}, cur);
      end
    end
    do_press(1'b0, 1'b1, "db_hold", 50);
  endtask

  task automatic test_capture();
    sum_in = 7'h4B;
    carry_in = 1'b1;
    do_press(1'b1, 1'b0, "cap_load", 0);
    sum_in = 7'h00;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      vec++;
      if (led !== 4'hC) begin
        bad++;
        $display("FAIL cap_iso k=%0d got=%h want=c", k, led);
      end
    end
    carry_in = 1'b0;
    do_press(1'b1, 1'b0, "cap_reload", 0);
    vec++;
    if (led !== 4'h0 || nib_idx !== 2'd1) begin
      bad++;
      $display("FAIL cap_new led=%h idx=%0d want 0/1", led, nib_idx);
    end
  endtask

  task automatic test_simultaneous();
    sum_in = 7'h4B;
    carry_in = 1'b1;
    do_press(1'b1, 1'b0, "sim_load", 0);
    do_press(1'b0, 1'b1, "sim_next", 0);
    sum_in = 7'h35;
    carry_in = 1'b0;
    do_press(1'b1, 1'b1, "sim_both", 0);
    vec++;
    if (led !== 4'h3 || nib_idx !== 2'd1) begin
      bad++;
      $display("FAIL sim_hi led=%h idx=%0d want 3/1", led, nib_idx);
    end
  endtask

  task automatic test_reset_mid();
    sum_in = 7'h4B;
    carry_in = 1'b1;
    do_press(1'b1, 1'b0, "rm_load", 0);
    do_press(1'b0, 1'b1, "rm_next", 0);
    vec++;
    if (led !== 4'hB) begin
      bad++;
      $display("FAIL rm_pre led=%h want=b", led);
    end
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    vec++;
    if ({led, nib_idx, done} !== 7'h00) begin
      bad++;
      $display("FAIL rm_async got=%h want=00", {led, nib_idx, done});
    end
    @(negedge clk);
    rstn = 1'b1;
    m_st = 0;
    m_res = 8'h00;
    do_press(1'b0, 1'b1, "rm_next_idle", 0);
  endtask

  initial begin
    test_reset();
    test_next_idle();
    test_readout();
    test_debounce();
    test_capture();
    test_simultaneous();
    test_reset_mid();
    vec++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_left got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/result_nibble_reader.md
Name: result_nibble_reader

Overview:
- Readout end of the nibble-loaded seven-bit adder: captures the 8-bit result {carry, z[6:0]} and presents it on four LEDs, one nibble per push-button press.
- Push buttons are raw and asynchronous. The block synchronises, debounces and edge-detects them internally.
- Sits between the adder outputs and the board LEDs.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed before a button level is accepted (minimum 1; board build uses a large value).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- sum_in  input  7  adder sum z.
- carry_in  input  1  adder carry.
- load_pb  input  1  raw button: capture the result and show the high nibble.
- next_pb  input  1  raw button: advance to the next nibble.
- led  output  4  displayed nibble.
- nib_idx  output  2  0 = blank/idle, 1 = high nibble, 2 = low nibble.
- done  output  1  one-cycle pulse after the low nibble is acknowledged.

Behaviour:
- Reset (rstn=0, asynchronous, immediate):
  - led=0, nib_idx=0, done=0, captured result=0, state IDLE.
  - Synchronisers, debounced levels and debounce counters clear to 0.
  - Assertion at any time, including mid-readout, aborts to IDLE.
- Button conditioning, per button, independent:
  - SYNC_STAGES-flop synchroniser.
  - Debounce counter: resets whenever synced level equals debounced level, otherwise increments. When it reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - Rising edge of the debounced level gives a one-cycle pulse (load_p / next_p). Falling edges give no pulse.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles is ignored.
- Latency: raw level held stable → debounced pulse exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first capturing edge. led/nib_idx change on the following edge. Total latency SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Result register res[7:0] = {carry_in, sum_in}:
  - Sampled only on the cycle load_p is high.
  - Input changes at other times do not affect led.
- FSM:
  - IDLE: led=0, nib_idx=0. load_p → HI (capture). next_p ignored.
  - HI: led=res[7:4], nib_idx=1. load_p → HI (recapture). next_p → LO.
  - LO: led=res[3:0], nib_idx=2. load_p → HI (recapture). next_p → IDLE with done=1 for exactly that transition cycle.
- Simultaneous load_p and next_p in the same cycle: load wins. Capture, go to HI, no done.
- Button held indefinitely produces exactly one pulse. A new pulse requires release (debounced 0) then press.
- led, nib_idx and done are registered. No combinational path from inputs to outputs.

Test Plan:
- Normal readout: sum_in=7'b1001011, carry_in=1, press load_pb → led=4'b1100, nib_idx=1 after SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles. Press next_pb → led=4'b1011, nib_idx=2. Press next_pb → led=0, nib_idx=0, done high for one cycle.
- Debounce: pulse next_pb for DEBOUNCE_CYCLES-1 cycles while in HI → no change. Hold next_pb for DEBOUNCE_CYCLES+2 cycles → moves to LO exactly once. Keep holding 50 cycles → no further change.
- Capture isolation: after load with res=8'hCB, change sum_in to 7'h00 → led stays 4'hC. Press load again → led=4'h0 (new res=8'h00, with carry_in=0).
- Simultaneous: in LO, press load_pb and next_pb on the same cycle with identical bounce-free timing → HI with recaptured value, done never asserts.
- Reset mid-operation: in LO with led=4'hB, drive rstn=0 between clock edges → led=0, nib_idx=0 before the next edge. After release, next_pb alone → remains IDLE.
- Next in IDLE: after reset, press next_pb → led=0, nib_idx=0, done=0 throughout.
